seg_scan_display: RTL

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display_pkg.sv | 20 ++
 rtl/seg_scan_display_hex_to_seg7.sv | 13 +
 rtl/seg_scan_display.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_display_pkg.sv
// rtl/seg_scan_display_pkg.sv - shared segment bit order and hex glyph table
package seg_scan_display_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [SEG_G:SEG_A] seg7_t;

    // Active-high glyphs for 0-9, A, b, C, d, E, F
    localparam seg7_t GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_scan_display_hex_to_seg7.sv
// rtl/seg_scan_display_hex_to_seg7.sv - combinational nibble to active-high glyph decoder
module hex_to_seg7
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    always_comb begin
        seg = GLYPH_TABLE[nibble];
    end

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed hex display scanner with frame-synchronous update and PWM dimming
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLOCK_DIVISOR  = 800,
    parameter int BRIGHT_BITS    = 3,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [6:0]              segments,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int DW = $clog2(CLOCK_DIVISOR);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = DW + BRIGHT_BITS + 1;

    localparam logic [DW-1:0]         DIV_LAST = DW'(CLOCK_DIVISOR - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DW-1:0]           div_q, div_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    term_cnt, boundary;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blank, cur_zero_run, all_zero;
    seg7_t                   cur_glyph;
    logic                    suppress, pwm_on;
    logic [6:0]              seg_on;
    logic [NUM_DIGITS-1:0]   an_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    always_comb begin
        term_cnt = (div_q == DIV_LAST);
        boundary = term_cnt && (idx_q == IDX_LAST);
        div_d    = term_cnt ? '0 : div_q + DW'(1);
        idx_d    = idx_q;
        if (term_cnt) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        // Look one cycle ahead so the registered pulse lands on the boundary cycle itself
        frame_done_d = (div_d == DIV_LAST) && (idx_d == IDX_LAST);

        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        busy_d       = busy_q;
        if (boundary && busy_q) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
            busy_d      = 1'b0;
        end
        if (load) begin
            pend_data_d  = data;
            pend_dp_d    = dp_in;
            pend_blank_d = blank;
            busy_d       = 1'b1;
        end
    end

    // all_zero accumulates from the top digit down, so it marks a leading-zero run
    always_comb begin
        cur_nib      = '0;
        cur_dp       = 1'b0;
        cur_blank    = 1'b0;
        cur_zero_run = 1'b0;
        all_zero     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (act_data_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                cur_nib      = act_data_q[4*i +: 4];
                cur_dp       = act_dp_q[i];
                cur_blank    = act_blank_q[i];
                cur_zero_run = all_zero;
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nib),
        .seg    (cur_glyph)
    );

    always_comb begin
        suppress = lz_suppress && (idx_q != '0) && cur_zero_run;
        pwm_on   = (PW'({div_q, {BRIGHT_BITS{1'b0}}}) <
                    (PW'(brightness) + PW'(1)) * PW'(CLOCK_DIVISOR));
        seg_on   = suppress ? 7'h00 : cur_glyph;
        an_on    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((idx_q == IW'(i)) && !cur_blank && pwm_on) begin
                an_on[i] = 1'b1;
            end
        end
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        dp_d  = (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
        an_d  = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
    end

    assign segments   = seg_q;
    assign dp_out     = dp_q;
    assign anodes     = an_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
